mem_lsu: RTL

//  MEM-stage load/store unit between the EX/MEM pipeline register and a handshaked data bus.

---
 rtl/mem_lsu_pkg.sv | 12 +
 rtl/mem_lsu_align.sv | 32 +++
 rtl/mem_lsu.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared LSU state encoding, funct3 codes and defaults
package mem_lsu_pkg;
    localparam int LSU_DATA_WIDTH = 64;
    localparam int LSU_ADDR_WIDTH = 64;
    localparam int LSU_WAIT_LIMIT = 255;
    localparam logic [2:0] F3_BU  = 3'd4;
    localparam logic [2:0] F3_BAD = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} lsu_state_t;
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        return sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
    endfunction
endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: byte-lane placement of stores and extraction/extension of loads
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic [2:0]            i_off,
    input  logic [2:0]            i_width,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_wdata_sh,
    output logic [7:0]            o_wstrb,
    output logic [DATA_WIDTH-1:0] o_rdata_ext,
    output logic                  o_misaligned
);
    logic [5:0]            w_sh;
    logic [5:0]            w_msb;
    logic [7:0]            w_bmask;
    logic [DATA_WIDTH-1:0] w_lmask;
    logic [DATA_WIDTH-1:0] w_shr;
    logic                  w_sign;
    assign w_sh         = {i_off, 3'b000};
    assign w_msb        = {i_width[1:0] == 2'd3, i_width[1], |i_width[1:0], 3'b111};
    assign w_bmask      = size_mask(i_width[1:0]);
    assign w_lmask      = (DATA_WIDTH'(2) << w_msb) - DATA_WIDTH'(1);
    assign w_shr        = i_rdata >> w_sh;
    assign w_sign       = (i_width < F3_BU) & w_shr[w_msb];
    assign o_rdata_ext  = (w_shr & w_lmask) | (w_sign ? ~w_lmask : '0);
    assign o_wdata_sh   = i_wdata << w_sh;
    assign o_wstrb      = w_bmask << i_off;
    assign o_misaligned = (i_width == F3_BAD) | (|(i_off & w_msb[5:3]));
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a handshaked doubleword bus
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
    parameter int WAIT_LIMIT = LSU_WAIT_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_re,
    input  logic                  i_mem_we,
    input  logic [2:0]            i_mem_data_width,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data_in,
    output logic                  o_lsu_stall,
    output logic                  o_lsu_valid,
    output logic [DATA_WIDTH-1:0] o_lsu_data_out,
    output logic                  o_lsu_misaligned,
    output logic                  o_lsu_bus_err,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    output logic [7:0]            o_bus_wstrb,
    input  logic                  i_bus_ready,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    lsu_state_t            r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_we;
    logic [2:0]            r_off;
    logic [2:0]            r_width;
    logic [2:0]            w_off;
    logic [2:0]            w_width;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [DATA_WIDTH-1:0] w_rdata_ext;
    logic [7:0]            w_wstrb;
    logic                  w_mis;
    logic                  w_expired;
    // In IDLE the aligner sees the live request; afterwards the captured access drives load extraction.
    assign w_off       = (r_state == ST_IDLE) ? i_mem_addr[2:0] : r_off;
    assign w_width     = (r_state == ST_IDLE) ? i_mem_data_width : r_width;
    assign w_expired   = r_cnt == CW'(WAIT_LIMIT - 1);
    assign o_lsu_stall = ~rst & (i_mem_re | i_mem_we) & (r_state != ST_DONE);
    mem_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_off        (w_off),
        .i_width      (w_width),
        .i_wdata      (i_mem_data_in),
        .i_rdata      (i_bus_rdata),
        .o_wdata_sh   (w_wdata_sh),
        .o_wstrb      (w_wstrb),
        .o_rdata_ext  (w_rdata_ext),
        .o_misaligned (w_mis)
    );
    // Access sequencer: capture, bus request, response wait with timeout, one-cycle completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_we             <= 1'b0;
            r_off            <= '0;
            r_width          <= '0;
            o_lsu_valid      <= 1'b0;
            o_lsu_data_out   <= '0;
            o_lsu_misaligned <= 1'b0;
            o_lsu_bus_err    <= 1'b0;
            o_bus_req        <= 1'b0;
            o_bus_we         <= 1'b0;
            o_bus_addr       <= '0;
            o_bus_wdata      <= '0;
            o_bus_wstrb      <= '0;
        end else begin
            o_lsu_valid      <= 1'b0;
            o_lsu_misaligned <= 1'b0;
            o_lsu_bus_err    <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_mem_re | i_mem_we) begin
                    r_we    <= i_mem_we;
                    r_off   <= i_mem_addr[2:0];
                    r_width <= i_mem_data_width;
                    if (w_mis) begin
                        r_state          <= ST_DONE;
                        o_lsu_valid      <= 1'b1;
                        o_lsu_misaligned <= 1'b1;
                        o_lsu_data_out   <= '0;
                    end else begin
                        r_state     <= ST_REQ;
                        r_cnt       <= '0;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_mem_we;
                        o_bus_addr  <= {i_mem_addr[ADDR_WIDTH-1:3], 3'b000};
                        o_bus_wdata <= i_mem_we ? w_wdata_sh : '0;
                        o_bus_wstrb <= i_mem_we ? w_wstrb : 8'h00;
                    end
                end
                ST_REQ: if (i_bus_ready) begin
                    r_state   <= ST_RESP;
                    r_cnt     <= '0;
                    o_bus_req <= 1'b0;
                end else if (w_expired) begin
                    r_state        <= ST_DONE;
                    o_bus_req      <= 1'b0;
                    o_lsu_valid    <= 1'b1;
                    o_lsu_bus_err  <= 1'b1;
                    o_lsu_data_out <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_RESP: if (i_bus_rvalid) begin
                    r_state        <= ST_DONE;
                    o_lsu_valid    <= 1'b1;
                    o_lsu_data_out <= r_we ? '0 : w_rdata_ext;
                end else if (w_expired) begin
                    r_state        <= ST_DONE;
                    o_lsu_valid    <= 1'b1;
                    o_lsu_bus_err  <= 1'b1;
                    o_lsu_data_out <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
